// File: rtl/matvec_host_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : matvec_host_ctrl                                           |
// | Description : Host-side controller for the matrix_mult engine. Loads    |
// |               A (DIMxDIM, row-major) then B (DIM) from a byte stream,   |
// |               issues clr/start, waits for the done edge, then streams   |
// |               the DIM results out over a valid/ready port.              |
// | Options     : define MVH_TIMEOUT_EN to enable the WAIT-state watchdog   |
// |               (sticky err, abort to CLR after TIMEOUT_CYC cycles).      |
// | Revision    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------------+
module matvec_host_ctrl #(
   parameter int DATA_W      = 8,
   parameter int DIM         = 8,
   parameter int ACC_W       = 24,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              mm_clr,
   output logic              mm_start,
   output logic [DATA_W-1:0] mm_a_data [DIM][DIM],
   output logic [DATA_W-1:0] mm_b_data [DIM],
   input  logic [ACC_W-1:0]  mm_c_out  [DIM],
   input  logic              mm_done,
   output logic              busy,
   output logic              err
);

   localparam int N_BYTES = DIM * DIM + DIM;
   localparam int IDX_W   = $clog2(N_BYTES);
   localparam int K_W     = (DIM > 1) ? $clog2(DIM) : 1;

   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_BYTES - 1);
   localparam logic [K_W-1:0]   c_LAST_K   = K_W'(DIM - 1);

   typedef enum logic [2:0] {
      S_CLR   = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [K_W-1:0]     r_k;
   logic               r_done_q;
   logic [DATA_W-1:0]  r_a   [DIM][DIM];
   logic [DATA_W-1:0]  r_b   [DIM];
   logic [ACC_W-1:0]   r_res [DIM];

   logic               w_accept;
   logic               w_out_fire;
   logic               w_done_edge;
   logic               w_capture;
   logic               w_timeout;

   assign w_accept    = in_valid && in_ready;
   assign w_out_fire  = out_valid && out_ready;
   // Only a fresh rising edge counts: a done level left over from a prior run is ignored.
   assign w_done_edge = mm_done && !r_done_q;
   assign w_capture   = (r_state == S_WAIT) && w_done_edge;

   assign mm_a_data = r_a;
   assign mm_b_data = r_b;
   assign out_data  = r_res[r_k];
   assign out_last  = out_valid && (r_k == c_LAST_K);

   // State register; reset parks the controller in CLR so mm_clr is asserted during reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_CLR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and handshake/strobe outputs, all decoded from the current state.
   always_comb begin
      w_state_nxt = r_state;
      mm_clr      = 1'b0;
      mm_start    = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         S_CLR: begin
            mm_clr      = 1'b1;
            w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid && (r_idx == c_LAST_IDX)) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            mm_start    = 1'b1;
            busy        = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (w_done_edge) begin
               w_state_nxt = S_DRAIN;
            end else if (w_timeout) begin
               w_state_nxt = S_CLR;
            end
         end
         S_DRAIN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready && (r_k == c_LAST_K)) begin
               w_state_nxt = S_CLR;
            end
         end
         default: begin
            w_state_nxt = S_CLR;
         end
      endcase
   end

   // Byte index and result index counters; both wrap to 0 on their final beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx    <= '0;
         r_k      <= '0;
         r_done_q <= 1'b0;
      end else begin
         r_done_q <= mm_done;
         if (w_accept) begin
            r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
         end
         if (w_out_fire) begin
            r_k <= (r_k == c_LAST_K) ? '0 : r_k + 1'b1;
         end
      end
   end

   // Operand capture: bytes 0..DIM*DIM-1 fill A row-major, the remainder fill B.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
               r_a[r][c] <= '0;
            end
            r_b[r] <= '0;
         end
      end else if (w_accept) begin
         for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
               if (r_idx == IDX_W'(r * DIM + c)) begin
                  r_a[r][c] <= in_data;
               end
            end
            if (r_idx == IDX_W'(DIM * DIM + r)) begin
               r_b[r] <= in_data;
            end
         end
      end
   end

   // Result capture on the done edge; held until the next capture or reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DIM; i++) begin
            r_res[i] <= '0;
         end
      end else if (w_capture) begin
         for (int i = 0; i < DIM; i++) begin
            r_res[i] <= mm_c_out[i];
         end
      end
   end

`ifdef MVH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_err;

   // Watchdog fires on the TIMEOUT_CYC-th WAIT cycle without a done edge.
   assign w_timeout = (r_state == S_WAIT) && !w_done_edge && (r_wait_cnt == c_CNT_LAST);
   assign err       = r_err;

   // WAIT-cycle counter, cleared in START so it restarts on every WAIT entry; err is sticky.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         if (r_state == S_START) begin
            r_wait_cnt <= '0;
         end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end
`else
   assign w_timeout = 1'b0;
   assign err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/matvec_host_ctrl.md
Name: matvec_host_ctrl

Overview:
Host-side controller that drives the matrix_mult engine from the other end of its operand/result interface. It accepts a byte stream of operands (DIM×DIM matrix A in row-major order, then DIM-element vector B) and presents them as parallel arrays. It then issues clr and start, waits for done, captures the DIM results and streams them out as words over a valid/ready port. It sits between the system byte link and matrix_mult.

Parameters:
DATA_W, 8, operand byte width
DIM, 8, matrix/vector dimension
ACC_W, 24, result word width (matches multiplier c_out)
TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with MVH_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
in_data  in  DATA_W  operand byte
in_valid  in  1  operand byte valid
in_ready  out  1  controller accepts operand byte
out_data  out  ACC_W  result word
out_valid  out  1  result word valid
out_ready  in  1  downstream accepts result word
out_last  out  1  marks final result word (index DIM-1)
mm_clr  out  1  accumulator clear to multiplier
mm_start  out  1  start pulse to multiplier
mm_a_data  out  DATA_W × [DIM][DIM] unpacked  matrix A to multiplier
mm_b_data  out  DATA_W × [DIM] unpacked  vector B to multiplier
mm_c_out  in  ACC_W × [DIM] unpacked  multiplier results
mm_done  in  1  multiplier completion
busy  out  1  high in START, WAIT, DRAIN
err  out  1  sticky watchdog error (tied 0 without MVH_TIMEOUT_EN)

Behaviour:
- States: CLR, LOAD, START, WAIT, DRAIN. Reset forces CLR.
- Reset values: idx=0, k=0, all A/B/result registers 0, done_q=0, err=0.
  - While rst is high: mm_clr=1; in_ready, out_valid, out_last, mm_start, busy=0.
- CLR: mm_clr=1 for exactly one cycle, then LOAD.
- LOAD: in_ready=1. A byte is accepted when in_valid && in_ready.
  - idx<DIM*DIM: byte goes to A[idx/DIM][idx%DIM].
  - Otherwise: byte goes to B[idx-DIM*DIM].
  - idx increments on each accepted byte. Gaps in in_valid are allowed.
  - Accepting byte idx=DIM*DIM+DIM-1 (71) moves to START and resets idx to 0.
- START: mm_start=1 for exactly one cycle, then WAIT. Operand arrays stay stable from START through DRAIN.
- WAIT: done_q is mm_done registered every cycle.
  - Completion is the rising edge mm_done && !done_q. A stale high done level from a prior run is ignored.
  - On the edge, capture all mm_c_out words into the result registers and move to DRAIN.
- DRAIN: out_valid=1, out_data=result[k], out_last=(k==DIM-1).
  - k increments on out_valid && out_ready.
  - out_data and out_valid hold while out_ready is low.
  - The transfer with out_last moves to CLR and resets k to 0. Next operation starts with a fresh clear.
- Result registers and err are cleared only by rst. Err is sticky.
- Reset mid-operation: immediate return to CLR. Partial loads and pending results are discarded; no output beat is emitted.
- Widths: results pass through unmodified. Maximum product sum DIM×255×255=0x7F008 fits ACC_W=24.
- in_valid during START/WAIT/DRAIN: ignored, since in_ready=0.

Optional Feature:
MVH_TIMEOUT_EN
- Defined: a cycle counter runs in WAIT. If it reaches TIMEOUT_CYC without a done edge:
  - err is set (sticky), the FSM goes to CLR, and no results are emitted.
  - The counter resets on entry to WAIT.
- Undefined: no counter; WAIT waits indefinitely; err is constant 0.

Test Plan:
- Row-sum load: A rows are {1..8}, {0x11..0x18}, all-2, all-3, all-4, all-5, all-6, all-7; B = all 1.
  - Expect one mm_start pulse after byte 72.
  - After a modeled done edge: out words 0x24, 0xA4, 0x10, 0x18, 0x20, 0x28, 0x30, 0x38; out_last on the 8th only.
- Max values: all operands 0xFF → every out_data = 0x07F008; no truncation.
- Backpressure: out_ready toggles every other cycle and in_valid has random gaps.
  - Expect identical result order, no dropped or duplicated words, and out_data stable while stalled.
- Stale done: hold mm_done high entering WAIT, drop it 3 cycles later, raise it at cycle 10 → capture occurs only at cycle 10.
- Mid-load reset: assert rst after 30 bytes, then load a full new 72-byte set.
  - Expect mm_clr pulse, idx restarts at 0, results reflect only the new set.
- Timeout (MVH_TIMEOUT_EN, TIMEOUT_CYC=16): never assert done.
  - Expect err=1 at WAIT cycle 16, return to CLR/LOAD, out_valid never asserted.
